// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI slave controller: FSM state encoding,
// command codes and the bit-counter width helper.
package spi_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    CHK_CMD   = 3'd1,
    WRITE     = 3'd2,
    READ_ADD  = 3'd3,
    READ_DATA = 3'd4,
    TX_WAIT   = 3'd5,
    TX_SHIFT  = 3'd6,
    DONE      = 3'd7
  } state_t;

  localparam logic [1:0] CMD_WR_ADDR = 2'b00;
  localparam logic [1:0] CMD_WR_DATA = 2'b01;
  localparam logic [1:0] CMD_RD_ADDR = 2'b10;
  localparam logic [1:0] CMD_RD_DATA = 2'b11;

  function automatic int cnt_width(input int data_w);
    return $clog2(data_w + 2);
  endfunction

endpackage

// File: rtl/spi_slave_fsm_if.sv
// Pin-side and RAM-side signals of the SPI slave controller, plus debug taps
// exposing the FSM state and the read-address flag.
// Handshake: rx_valid and frame_err are single-cycle strobes with no back-pressure;
// tx_valid qualifies tx_data only while the slave is waiting for read data.
interface spi_slave_fsm_if
  import spi_pkg::*;
#(
  parameter int DATA_W = 8
);
  logic              SS_n;
  logic              MOSI;
  logic              tx_valid;
  logic [DATA_W-1:0] tx_data;
  logic [DATA_W+1:0] rx_data;
  logic              rx_valid;
  logic              MISO;
  logic              frame_err;
  state_t            dbg_state;
  logic              dbg_rd_addr_done;

  modport slave (
    input  SS_n, MOSI, tx_valid, tx_data,
    output rx_data, rx_valid, MISO, frame_err, dbg_state, dbg_rd_addr_done
  );

  modport master (
    output SS_n, MOSI, tx_valid, tx_data,
    input  rx_data, rx_valid, MISO, frame_err, dbg_state, dbg_rd_addr_done
  );
endinterface

// File: rtl/spi_sipo.sv
// Serial-in/parallel-out register: shifts MSB first, publishes the word and a
// one-cycle done strobe once WIDTH bits have been taken in.
module spi_sipo #(
  parameter int WIDTH = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             shift_en,
  input  logic             din,
  output logic [WIDTH-1:0] data,
  output logic             done
);
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  logic [WIDTH-1:0] sr;
  logic [CW-1:0]    cnt;

  // clear only drops the partial word; the last published word is kept
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr   <= '0;
      cnt  <= '0;
      data <= '0;
      done <= 1'b0;
    end else begin
      done <= 1'b0;
      if (clear) begin
        sr  <= '0;
        cnt <= '0;
      end else if (shift_en) begin
        if (cnt == LAST) begin
          data <= {sr[WIDTH-2:0], din};
          done <= 1'b1;
          sr   <= '0;
          cnt  <= '0;
        end else begin
          sr  <= {sr[WIDTH-2:0], din};
          cnt <= cnt + 1'b1;
        end
      end
    end
  end
endmodule

// File: rtl/spi_slave_fsm.sv
// SPI slave protocol controller: decodes command frames into rx_data/rx_valid and
// shifts RAM read data out on MISO, with bounded wait for tx_valid and abort reporting.
module spi_slave_fsm
  import spi_pkg::*;
#(
  parameter int DATA_W       = 8,
  parameter bit TX_MSB_FIRST = 1'b1,
  parameter int TX_WAIT_MAX  = 15
) (
  input  logic            clk,
  input  logic            rst_n,
  spi_slave_fsm_if.slave  bus
);
  localparam int CNT_W  = cnt_width(DATA_W);
  localparam int WAIT_W = $clog2(TX_WAIT_MAX + 1);
  localparam logic [CNT_W-1:0]  RX_LAST   = CNT_W'(DATA_W);
  localparam logic [CNT_W-1:0]  TX_LAST   = CNT_W'(DATA_W - 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TX_WAIT_MAX - 1);

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    bit_cnt_q, bit_cnt_d;
  logic [WAIT_W-1:0]   wait_cnt_q, wait_cnt_d;
  logic                rd_addr_done_q, rd_addr_done_d;
  logic [DATA_W-1:0]   tx_sr_q, tx_sr_d;
  logic                miso_q, miso_d;
  logic                frame_err_q, frame_err_d;
  logic                sipo_shift, sipo_clear, rx_last;

  spi_sipo #(.WIDTH(DATA_W + 2)) u_sipo (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear    (sipo_clear),
    .shift_en (sipo_shift),
    .din      (bus.MOSI),
    .data     (bus.rx_data),
    .done     (bus.rx_valid)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      bit_cnt_q      <= '0;
      wait_cnt_q     <= '0;
      rd_addr_done_q <= 1'b0;
      tx_sr_q        <= '0;
      miso_q         <= 1'b0;
      frame_err_q    <= 1'b0;
    end else begin
      state_q        <= state_d;
      bit_cnt_q      <= bit_cnt_d;
      wait_cnt_q     <= wait_cnt_d;
      rd_addr_done_q <= rd_addr_done_d;
      tx_sr_q        <= tx_sr_d;
      miso_q         <= miso_d;
      frame_err_q    <= frame_err_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    bit_cnt_d      = bit_cnt_q;
    wait_cnt_d     = wait_cnt_q;
    rd_addr_done_d = rd_addr_done_q;
    tx_sr_d        = tx_sr_q;
    miso_d         = 1'b0;
    frame_err_d    = 1'b0;
    sipo_shift     = 1'b0;
    sipo_clear     = 1'b0;
    rx_last        = 1'b0;

    case (state_q)
      IDLE: begin
        sipo_clear = 1'b1;
        bit_cnt_d  = '0;
        wait_cnt_d = '0;
        if (!bus.SS_n) state_d = CHK_CMD;
      end
      CHK_CMD: begin
        sipo_shift = 1'b1;
        if (!bus.MOSI)          state_d = WRITE;
        else if (rd_addr_done_q) state_d = READ_DATA;
        else                     state_d = READ_ADD;
      end
      WRITE, READ_ADD, READ_DATA: begin
        sipo_shift = 1'b1;
        if (bit_cnt_q == RX_LAST) begin
          rx_last   = 1'b1;
          bit_cnt_d = '0;
          state_d   = (state_q == READ_DATA) ? TX_WAIT : DONE;
          if (state_q == READ_ADD) rd_addr_done_d = 1'b1;
        end else begin
          bit_cnt_d = bit_cnt_q + 1'b1;
        end
      end
      TX_WAIT: begin
        if (bus.tx_valid) begin
          // first bit goes straight to the MISO register; the rest queue in tx_sr
          miso_d     = TX_MSB_FIRST ? bus.tx_data[DATA_W-1] : bus.tx_data[0];
          tx_sr_d    = TX_MSB_FIRST ? (bus.tx_data << 1) : (bus.tx_data >> 1);
          bit_cnt_d  = '0;
          wait_cnt_d = '0;
          state_d    = TX_SHIFT;
        end else if (wait_cnt_q == WAIT_LAST) begin
          frame_err_d    = 1'b1;
          rd_addr_done_d = 1'b0;
          wait_cnt_d     = '0;
          state_d        = DONE;
        end else begin
          wait_cnt_d = wait_cnt_q + 1'b1;
        end
      end
      TX_SHIFT: begin
        if (bit_cnt_q == TX_LAST) begin
          rd_addr_done_d = 1'b0;
          bit_cnt_d      = '0;
          state_d        = DONE;
        end else begin
          miso_d    = TX_MSB_FIRST ? tx_sr_q[DATA_W-1] : tx_sr_q[0];
          tx_sr_d   = TX_MSB_FIRST ? (tx_sr_q << 1) : (tx_sr_q >> 1);
          bit_cnt_d = bit_cnt_q + 1'b1;
        end
      end
      DONE: begin
        state_d = DONE;
      end
      default: state_d = IDLE;
    endcase

    // Deselect wins over everything, except that a frame finishing on this edge still completes
    if (state_q != IDLE && bus.SS_n) begin
      state_d    = IDLE;
      bit_cnt_d  = '0;
      wait_cnt_d = '0;
      miso_d     = 1'b0;
      tx_sr_d    = tx_sr_q;
      if (!rx_last) begin
        sipo_shift     = 1'b0;
        sipo_clear     = 1'b1;
        rd_addr_done_d = rd_addr_done_q;
        frame_err_d    = (state_q != DONE);
      end
    end
  end

  assign bus.MISO             = miso_q;
  assign bus.frame_err        = frame_err_q;
  assign bus.dbg_state        = state_q;
  assign bus.dbg_rd_addr_done = rd_addr_done_q;
endmodule

// File: tb/tb_spi_slave_fsm.sv
// Bench for spi_slave_fsm: an MSB-first and an LSB-first instance driven in lockstep,
// with received words scoreboarded and MISO/strobe timing checked per scenario.
module tb_spi_slave_fsm;
  import spi_pkg::*;

  localparam int DW = 8;

  logic clk, rst_n;
  logic ss_n, mosi, tx_valid;
  logic [DW-1:0] tx_data;

  int n_cmp = 0;
  int n_err = 0;
  logic [DW+1:0] exp_q[$];
  logic [DW+1:0] mon_exp;

  spi_slave_fsm_if #(.DATA_W(DW)) bus_m ();
  spi_slave_fsm_if #(.DATA_W(DW)) bus_l ();

  assign bus_m.SS_n = ss_n;  assign bus_m.MOSI = mosi;
  assign bus_m.tx_valid = tx_valid;  assign bus_m.tx_data = tx_data;
  assign bus_l.SS_n = ss_n;  assign bus_l.MOSI = mosi;
  assign bus_l.tx_valid = tx_valid;  assign bus_l.tx_data = tx_data;

  spi_slave_fsm #(.DATA_W(DW), .TX_MSB_FIRST(1'b1), .TX_WAIT_MAX(15)) dut_msb (
    .clk(clk), .rst_n(rst_n), .bus(bus_m));
  spi_slave_fsm #(.DATA_W(DW), .TX_MSB_FIRST(1'b0), .TX_WAIT_MAX(15)) dut_lsb (
    .clk(clk), .rst_n(rst_n), .bus(bus_l));

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // scoreboard monitor: every rx_valid pops one expected word
  always @(negedge clk) begin
    if (rst_n && (bus_m.rx_valid || bus_l.rx_valid)) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL rx_unexpected: got msb=%h lsb=%h, expected no word", bus_m.rx_data, bus_l.rx_data);
      end else begin
        mon_exp = exp_q.pop_front();
        if (bus_m.rx_data !== mon_exp || bus_l.rx_data !== mon_exp ||
            bus_m.rx_valid !== 1'b1 || bus_l.rx_valid !== 1'b1) begin
          n_err++;
          $display("FAIL rx_word: got msb=%h/%b lsb=%h/%b, expected %h/1",
                   bus_m.rx_data, bus_m.rx_valid, bus_l.rx_data, bus_l.rx_valid, mon_exp);
        end
      end
    end
    if (rst_n && ((bus_m.rx_valid && bus_m.frame_err) || (bus_l.rx_valid && bus_l.frame_err))) begin
      n_cmp++;
      n_err++;
      $display("FAIL strobe_overlap: got rx_valid=1 frame_err=1, expected never both");
    end
  end

  // driver tasks
  task automatic drive_bits(input logic [DW+1:0] word, input int nbits, input bit push, input bit ss_on_last);
    @(negedge clk);
    ss_n = 1'b0;
    mosi = 1'b0;
    for (int i = 0; i < nbits; i++) begin
      @(negedge clk);
      mosi = word[DW+1-i];
      if (ss_on_last && i == nbits - 1) ss_n = 1'b1;
    end
    if (push) exp_q.push_back(word);
  endtask

  task automatic finish_frame();
    @(negedge clk);
    ss_n = 1'b1;
    mosi = 1'b0;
    @(negedge clk);
  endtask

  // scenarios
  task automatic test_reset();
    rst_n = 1'b0; ss_n = 1'b1; mosi = 1'b0; tx_valid = 1'b0; tx_data = '0;
    @(negedge clk);
    n_cmp++;
    if (bus_m.rx_data !== '0 || bus_m.rx_valid !== 1'b0 || bus_m.MISO !== 1'b0 || bus_m.frame_err !== 1'b0 ||
        bus_m.dbg_state !== IDLE || bus_m.dbg_rd_addr_done !== 1'b0 || bus_l.MISO !== 1'b0 || bus_l.dbg_state !== IDLE) begin
      n_err++;
      $display("FAIL reset_values: got rx=%h v=%b miso=%b err=%b st=%0d rd=%b, expected all 0 / IDLE",
               bus_m.rx_data, bus_m.rx_valid, bus_m.MISO, bus_m.frame_err, bus_m.dbg_state, bus_m.dbg_rd_addr_done);
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    n_cmp++;
    if (bus_m.dbg_state !== IDLE || bus_m.frame_err !== 1'b0) begin
      n_err++;
      $display("FAIL idle_after_reset: got st=%0d err=%b, expected IDLE/0", bus_m.dbg_state, bus_m.frame_err);
    end
  endtask

  task automatic test_write_addr();
    tx_valid = 1'b1;
    tx_data  = 8'hFF;
    drive_bits({CMD_WR_ADDR, 8'hA5}, DW + 2, 1'b1, 1'b0);
    @(negedge clk);
    n_cmp++;
    if (bus_m.rx_valid !== 1'b1 || bus_m.dbg_state !== DONE || bus_m.MISO !== 1'b0 || bus_m.frame_err !== 1'b0) begin
      n_err++;
      $display("FAIL wr_addr_complete: got v=%b st=%0d miso=%b err=%b, expected 1/DONE/0/0",
               bus_m.rx_valid, bus_m.dbg_state, bus_m.MISO, bus_m.frame_err);
    end
    // SS_n stays low: MOSI traffic in DONE must not start anything
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_cmp++;
      if (bus_m.rx_valid !== 1'b0 || bus_m.dbg_state !== DONE || bus_m.MISO !== 1'b0 || bus_l.MISO !== 1'b0) begin
        n_err++;
        $display("FAIL done_hold: got v=%b st=%0d miso=%b/%b, expected 0/DONE/0/0",
                 bus_m.rx_valid, bus_m.dbg_state, bus_m.MISO, bus_l.MISO);
      end
      mosi = 1'($urandom_range(0, 1));
    end
    tx_valid = 1'b0;
    finish_frame();
    n_cmp++;
    if (bus_m.dbg_state !== IDLE || bus_m.frame_err !== 1'b0) begin
      n_err++;
      $display("FAIL wr_addr_release: got st=%0d err=%b, expected IDLE/0", bus_m.dbg_state, bus_m.frame_err);
    end
  endtask

  task automatic test_read_seq(input logic [DW-1:0] d);
    logic [DW-1:0] dummy;
    drive_bits({CMD_RD_ADDR, 8'h0F}, DW + 2, 1'b1, 1'b0);
    @(negedge clk);
    n_cmp++;
    if (bus_m.rx_valid !== 1'b1 || bus_m.dbg_rd_addr_done !== 1'b1 || bus_l.dbg_rd_addr_done !== 1'b1) begin
      n_err++;
      $display("FAIL rd_addr_flag: got v=%b rd=%b/%b, expected 1/1/1",
               bus_m.rx_valid, bus_m.dbg_rd_addr_done, bus_l.dbg_rd_addr_done);
    end
    finish_frame();
    dummy = DW'($urandom_range(0, 255));
    drive_bits({CMD_RD_DATA, dummy}, DW + 2, 1'b1, 1'b0);
    @(negedge clk);
    n_cmp++;
    if (bus_m.rx_valid !== 1'b1 || bus_m.dbg_state !== TX_WAIT || bus_m.MISO !== 1'b0) begin
      n_err++;
      $display("FAIL rd_data_rx: got v=%b st=%0d miso=%b, expected 1/TX_WAIT/0",
               bus_m.rx_valid, bus_m.dbg_state, bus_m.MISO);
    end
    @(negedge clk);
    tx_valid = 1'b1;
    tx_data  = d;
    for (int i = 0; i < DW; i++) begin
      @(negedge clk);
      tx_valid = 1'b0;
      tx_data  = DW'($urandom_range(0, 255));
      n_cmp++;
      if (bus_m.MISO !== d[DW-1-i] || bus_l.MISO !== d[i]) begin
        n_err++;
        $display("FAIL miso_bit%0d: got msb=%b lsb=%b, expected msb=%b lsb=%b (data %h)",
                 i, bus_m.MISO, bus_l.MISO, d[DW-1-i], d[i], d);
      end
    end
    @(negedge clk);
    n_cmp++;
    if (bus_m.MISO !== 1'b0 || bus_l.MISO !== 1'b0 || bus_m.dbg_state !== DONE ||
        bus_m.dbg_rd_addr_done !== 1'b0 || bus_l.dbg_rd_addr_done !== 1'b0) begin
      n_err++;
      $display("FAIL tx_end: got miso=%b/%b st=%0d rd=%b/%b, expected 0/0/DONE/0/0",
               bus_m.MISO, bus_l.MISO, bus_m.dbg_state, bus_m.dbg_rd_addr_done, bus_l.dbg_rd_addr_done);
    end
    finish_frame();
  endtask

  task automatic test_abort();
    drive_bits({CMD_WR_DATA, 8'h3C}, 5, 1'b0, 1'b0);
    @(negedge clk);
    ss_n = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (bus_m.frame_err !== 1'b1 || bus_l.frame_err !== 1'b1 || bus_m.rx_valid !== 1'b0 || bus_m.dbg_state !== IDLE) begin
      n_err++;
      $display("FAIL abort_strobe: got err=%b/%b v=%b st=%0d, expected 1/1/0/IDLE",
               bus_m.frame_err, bus_l.frame_err, bus_m.rx_valid, bus_m.dbg_state);
    end
    @(negedge clk);
    n_cmp++;
    if (bus_m.frame_err !== 1'b0) begin
      n_err++;
      $display("FAIL abort_one_cycle: got err=%b, expected 0", bus_m.frame_err);
    end
    drive_bits({CMD_WR_DATA, 8'h3C}, DW + 2, 1'b1, 1'b0);
    @(negedge clk);
    n_cmp++;
    if (bus_m.rx_valid !== 1'b1 || bus_m.dbg_state !== DONE || bus_m.frame_err !== 1'b0) begin
      n_err++;
      $display("FAIL post_abort_frame: got v=%b st=%0d err=%b, expected 1/DONE/0",
               bus_m.rx_valid, bus_m.dbg_state, bus_m.frame_err);
    end
    finish_frame();
  endtask

  task automatic test_ss_at_last_bit();
    drive_bits({CMD_WR_ADDR, 8'($urandom_range(0, 255))}, DW + 2, 1'b1, 1'b1);
    @(negedge clk);
    n_cmp++;
    if (bus_m.rx_valid !== 1'b1 || bus_m.dbg_state !== IDLE || bus_m.frame_err !== 1'b0) begin
      n_err++;
      $display("FAIL ss_last_bit: got v=%b st=%0d err=%b, expected 1/IDLE/0",
               bus_m.rx_valid, bus_m.dbg_state, bus_m.frame_err);
    end
    @(negedge clk);
    n_cmp++;
    if (bus_m.frame_err !== 1'b0 || bus_m.rx_valid !== 1'b0 || bus_m.dbg_state !== IDLE) begin
      n_err++;
      $display("FAIL ss_last_bit_after: got err=%b v=%b st=%0d, expected 0/0/IDLE",
               bus_m.frame_err, bus_m.rx_valid, bus_m.dbg_state);
    end
  endtask

  task automatic test_timeout();
    drive_bits({CMD_RD_ADDR, 8'h55}, DW + 2, 1'b1, 1'b0);
    finish_frame();
    drive_bits({CMD_RD_DATA, 8'h00}, DW + 2, 1'b1, 1'b0);
    @(negedge clk);
    n_cmp++;
    if (bus_m.dbg_state !== TX_WAIT || bus_m.rx_valid !== 1'b1) begin
      n_err++;
      $display("FAIL to_enter: got st=%0d v=%b, expected TX_WAIT/1", bus_m.dbg_state, bus_m.rx_valid);
    end
    for (int k = 1; k < 15; k++) begin
      @(negedge clk);
      n_cmp++;
      if (bus_m.frame_err !== 1'b0 || bus_m.MISO !== 1'b0 || bus_m.dbg_state !== TX_WAIT) begin
        n_err++;
        $display("FAIL to_wait%0d: got err=%b miso=%b st=%0d, expected 0/0/TX_WAIT",
                 k, bus_m.frame_err, bus_m.MISO, bus_m.dbg_state);
      end
    end
    @(negedge clk);
    n_cmp++;
    if (bus_m.frame_err !== 1'b1 || bus_l.frame_err !== 1'b1 || bus_m.MISO !== 1'b0 ||
        bus_m.dbg_rd_addr_done !== 1'b0 || bus_m.dbg_state !== DONE) begin
      n_err++;
      $display("FAIL to_expire: got err=%b/%b miso=%b rd=%b st=%0d, expected 1/1/0/0/DONE",
               bus_m.frame_err, bus_l.frame_err, bus_m.MISO, bus_m.dbg_rd_addr_done, bus_m.dbg_state);
    end
    @(negedge clk);
    n_cmp++;
    if (bus_m.frame_err !== 1'b0) begin
      n_err++;
      $display("FAIL to_one_cycle: got err=%b, expected 0", bus_m.frame_err);
    end
    finish_frame();
  endtask

  task automatic test_back_to_back();
    for (int n = 0; n < 4; n++) begin
      drive_bits({1'b0, 1'($urandom_range(0, 1)), 8'($urandom_range(0, 255))}, DW + 2, 1'b1, 1'b0);
      @(negedge clk);
      n_cmp++;
      if (bus_m.rx_valid !== 1'b1 || bus_m.frame_err !== 1'b0) begin
        n_err++;
        $display("FAIL b2b_%0d: got v=%b err=%b, expected 1/0", n, bus_m.rx_valid, bus_m.frame_err);
      end
      finish_frame();
    end
  endtask

  task automatic test_reset_mid_frame();
    drive_bits({CMD_RD_ADDR, 8'h01}, DW + 2, 1'b1, 1'b0);
    finish_frame();
    drive_bits({CMD_RD_DATA, 8'h02}, DW + 2, 1'b1, 1'b0);
    @(negedge clk);
    tx_valid = 1'b1;
    tx_data  = 8'hFF;
    @(negedge clk);
    tx_valid = 1'b0;
    n_cmp++;
    if (bus_m.MISO !== 1'b1 || bus_m.dbg_state !== TX_SHIFT) begin
      n_err++;
      $display("FAIL pre_reset_shift: got miso=%b st=%0d, expected 1/TX_SHIFT", bus_m.MISO, bus_m.dbg_state);
    end
    #2 rst_n = 1'b0;
    ss_n = 1'b1;
    #1;
    n_cmp++;
    if (bus_m.MISO !== 1'b0 || bus_l.MISO !== 1'b0 || bus_m.rx_data !== '0 || bus_m.rx_valid !== 1'b0 ||
        bus_m.frame_err !== 1'b0 || bus_m.dbg_state !== IDLE || bus_m.dbg_rd_addr_done !== 1'b0) begin
      n_err++;
      $display("FAIL async_reset: got miso=%b/%b rx=%h v=%b err=%b st=%0d rd=%b, expected all 0 / IDLE",
               bus_m.MISO, bus_l.MISO, bus_m.rx_data, bus_m.rx_valid, bus_m.frame_err,
               bus_m.dbg_state, bus_m.dbg_rd_addr_done);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_write_addr();
    test_read_seq(8'hC3);
    test_read_seq(8'hA1);
    test_abort();
    test_ss_at_last_bit();
    test_timeout();
    test_back_to_back();
    test_reset_mid_frame();
    repeat (2) @(negedge clk);
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL scoreboard_drain: got %0d words outstanding, expected 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
